control_aforo: RTL

Occupancy controller placed after the two-sensor direction detector (`ingreso`/`egreso` one-cycle pulses). It keeps a saturating head-count and sequences entry permission through an FSM. It raises a timed alarm when someone enters a full room, and a sticky error on exit underflow. All outputs are registered and drive the gate enable and indicator/display logic.

---
 rtl/control_aforo_pkg.sv | 16 +
 rtl/control_aforo_temporizador_alarma.sv | 26 ++
 rtl/control_aforo.sv | 88 ++++++++
 3 files changed

// File: rtl/control_aforo_pkg.sv
// control_aforo_pkg: shared FSM state encodings and net-event codes for the occupancy controller
//   LIBRE/LLENO/ALARMA : FSM state constants
//   evento_t / evento() : reduces the ingreso/egreso pair to NONE, INC or DEC
package control_aforo_pkg;

   localparam logic [1:0] LIBRE  = 2'd0;
   localparam logic [1:0] LLENO  = 2'd1;
   localparam logic [1:0] ALARMA = 2'd2;

   typedef enum logic [1:0] {NONE, INC, DEC} evento_t;

   function automatic evento_t evento(input logic ing, input logic egr);
      return (ing && !egr) ? INC : (egr && !ing) ? DEC : NONE;
   endfunction

endpackage

// File: rtl/control_aforo_temporizador_alarma.sv
// temporizador_alarma: alarm down-counter
//   clk, reset : clock and synchronous active-high reset
//   load       : reloads the counter with T_ALARMA-1
//   fin        : high while the counter is 0
module temporizador_alarma #(
   parameter int T_ALARMA = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic fin
);

   localparam int TW = $clog2(T_ALARMA + 1);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb cnt_d = load ? TW'(T_ALARMA - 1) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

   always_ff @(posedge clk)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;

   assign fin = cnt_q == '0;

endmodule

// File: rtl/control_aforo.sv
// control_aforo: saturating occupancy counter with entry-permission FSM, timed intrusion alarm and sticky underflow error
//   clk, reset          : clock and synchronous active-high reset
//   ingreso, egreso     : one-cycle entry/exit pulses
//   clr_error           : clears the sticky error flag
//   cuenta, vacio, lleno: registered occupancy and its empty/full flags
//   habilitado, alarma  : entry permitted / intrusion alarm
//   error               : sticky exit-underflow flag
module control_aforo
   import control_aforo_pkg::*;
#(
   parameter int CAPACIDAD = 9,
   parameter int WIDTH     = 4,
   parameter int T_ALARMA  = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ingreso,
   input  logic             egreso,
   input  logic             clr_error,
   output logic [WIDTH-1:0] cuenta,
   output logic             vacio,
   output logic             lleno,
   output logic             habilitado,
   output logic             alarma,
   output logic             error
);

   if ((2 ** WIDTH) <= CAPACIDAD) begin : g_width_check
      $error("control_aforo: WIDTH too small for CAPACIDAD");
   end

   localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACIDAD);

   evento_t          ev;
   logic [1:0]       estado_q, estado_d;
   logic [WIDTH-1:0] cuenta_q, cuenta_d;
   logic             vacio_q, lleno_q, hab_q, alarma_q, error_q;
   logic             error_d, recarga, fin;

   always_comb begin
      ev       = evento(ingreso, egreso);
      cuenta_d = ev == INC ? (cuenta_q == CAP ? cuenta_q : cuenta_q + 1'b1)
               : ev == DEC ? (cuenta_q == '0 ? cuenta_q : cuenta_q - 1'b1)
               : cuenta_q;
      error_d  = (ev == DEC && cuenta_q == '0) ? 1'b1 : clr_error ? 1'b0 : error_q;
      // any entry while full or alarmed (re)starts the alarm window
      recarga  = ev == INC && (estado_q == LLENO || estado_q == ALARMA);
      // exits are decided on the post-event count so lleno and habilitado never disagree
      estado_d = estado_q == LIBRE ? ((ev == INC && cuenta_d == CAP) ? LLENO : LIBRE)
               : estado_q == LLENO ? (ev == DEC ? LIBRE : ev == INC ? ALARMA : LLENO)
               : estado_q == ALARMA ? ((recarga || !fin) ? ALARMA : (cuenta_d == CAP ? LLENO : LIBRE))
               : LIBRE;
   end

   temporizador_alarma #(.T_ALARMA(T_ALARMA)) u_temporizador (
      .clk  (clk),
      .reset(reset),
      .load (recarga),
      .fin  (fin)
   );

   always_ff @(posedge clk)
      if (reset) begin
         estado_q <= LIBRE;
         cuenta_q <= '0;
         vacio_q  <= 1'b1;
         lleno_q  <= 1'b0;
         hab_q    <= 1'b1;
         alarma_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         cuenta_q <= cuenta_d;
         vacio_q  <= cuenta_d == '0;
         lleno_q  <= cuenta_d == CAP;
         hab_q    <= estado_d == LIBRE;
         alarma_q <= estado_d == ALARMA;
         error_q  <= error_d;
      end

   assign cuenta     = cuenta_q;
   assign vacio      = vacio_q;
   assign lleno      = lleno_q;
   assign habilitado = hab_q;
   assign alarma     = alarma_q;
   assign error      = error_q;

endmodule
